// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, screen geometry and arbiter state type for the VGA
// plot arbiter slice.
//   X_W / Y_W / COLOUR_W : pixel coordinate and colour widths.
//   SCREEN_W / SCREEN_H  : visible area; coordinates at or beyond are off-screen.
//   arb_state_t          : arbiter FSM state encoding.
//   idx_width()          : width of an index into N requesters (minimum 1).
package vga_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [0:0] {
        S_idle  = 1'b0,
        S_grant = 1'b1
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: bundle between the pixel requesters, the arbiter and
// the VGA adapter.
//   req, x_in, y_in, colour_in : per-requester request/beat-valid and packed pixel.
//   gnt, busy                  : one-hot registered grant and grant-held flag.
//   vga_x, vga_y, vga_colour   : registered pixel towards the adapter.
//   vga_plot                   : adapter write enable.
//   oob_flag                   : sticky out-of-bounds indicator.
// Modports: master = requester/adapter side, slave = arbiter side.
interface vga_plot_arbiter_if #(
    parameter int unsigned N_REQ = 3
);

    logic [N_REQ-1:0]                   req;
    logic [N_REQ*vga_pkg::X_W-1:0]      x_in;
    logic [N_REQ*vga_pkg::Y_W-1:0]      y_in;
    logic [N_REQ*vga_pkg::COLOUR_W-1:0] colour_in;
    logic [N_REQ-1:0]                   gnt;
    logic                               busy;
    logic [vga_pkg::X_W-1:0]            vga_x;
    logic [vga_pkg::Y_W-1:0]            vga_y;
    logic [vga_pkg::COLOUR_W-1:0]       vga_colour;
    logic                               vga_plot;
    logic                               oob_flag;

    modport master (
        output req, x_in, y_in, colour_in,
        input  gnt, busy, vga_x, vga_y, vga_colour, vga_plot, oob_flag
    );

    modport slave (
        input  req, x_in, y_in, colour_in,
        output gnt, busy, vga_x, vga_y, vga_colour, vga_plot, oob_flag
    );

endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin select.
//   req        : per-requester request vector.
//   rr_ptr     : highest-priority requester index for this round.
//   winner     : one-hot winner (all zero when nothing requests).
//   winner_idx : binary index of the winner.
//   any_req    : at least one request is present.
module rr_picker
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] cand;

    // Scan starting at rr_ptr, wrapping modulo N_REQ; first hit wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % N_REQ);
            if (!any_req && req[cand]) begin
                any_req      = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin arbiter granting exclusive access to the VGA
// adapter write port, with a per-grant burst limit.
//   clock : sole clock, rising edge.
//   reset : asynchronous, active-high.
//   bus   : vga_plot_arbiter_if.slave (requests/pixels in, grant and VGA pixel out).
// Parameters: N_REQ requesters, BURST_MAX accepted beats per grant (1..256).
// Optional feature: define PLOT_BOUNDS_CHECK_EN to suppress plotting of beats
// with x >= SCREEN_W or y >= SCREEN_H and raise a sticky oob_flag instead.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned N_REQ     = 3,
    parameter int unsigned BURST_MAX = 64
) (
    input  logic               clock,
    input  logic               reset,
    vga_plot_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W     = idx_width(N_REQ);
    localparam logic [7:0]  LAST_BEAT = 8'(BURST_MAX - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner;
    logic [7:0]           counter;
    logic [N_REQ-1:0]     grant;
    logic                 busy_reg;
    logic [X_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic [COLOUR_W-1:0]  pix_colour;
    logic                 plot;

    logic [N_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic                 owner_req;
    logic                 owner_gnt;
    logic [X_W-1:0]       beat_x;
    logic [Y_W-1:0]       beat_y;
    logic [COLOUR_W-1:0]  beat_colour;
    logic                 accept;
    logic                 beat_oob;
    logic                 leave;
    logic [IDX_W-1:0]     next_ptr;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req        (bus.req),
        .rr_ptr     (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    // Select the owner's request, grant bit and pixel fields.
    always_comb begin
        owner_req   = 1'b0;
        owner_gnt   = 1'b0;
        beat_x      = '0;
        beat_y      = '0;
        beat_colour = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_req   = bus.req[i];
                owner_gnt   = grant[i];
                beat_x      = bus.x_in[i*X_W +: X_W];
                beat_y      = bus.y_in[i*Y_W +: Y_W];
                beat_colour = bus.colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // grant is only non-zero in S_grant, so this also qualifies on state.
    assign accept   = owner_req & owner_gnt;
    // Release on a dropped request, or after the last beat of the burst is taken.
    assign leave    = !owner_req || (accept && (counter == LAST_BEAT));
    assign next_ptr = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef PLOT_BOUNDS_CHECK_EN
    logic oob_sticky;

    assign beat_oob = (beat_x >= X_W'(SCREEN_W)) || (beat_y >= Y_W'(SCREEN_H));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oob_sticky <= 1'b0;
        end else if (accept && beat_oob) begin
            oob_sticky <= 1'b1;
        end
    end

    assign bus.oob_flag = oob_sticky;
`else
    assign beat_oob     = 1'b0;
    assign bus.oob_flag = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_idle;
            rr_ptr     <= '0;
            owner      <= '0;
            counter    <= '0;
            grant      <= '0;
            busy_reg   <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            plot       <= 1'b0;
        end else begin
            plot <= 1'b0;
            // An off-screen beat is consumed and counted but leaves the pixel alone.
            if (accept && !beat_oob) begin
                pix_x      <= beat_x;
                pix_y      <= beat_y;
                pix_colour <= beat_colour;
                plot       <= 1'b1;
            end

            case (state)
                S_idle: begin
                    if (pick_any) begin
                        state    <= S_grant;
                        owner    <= pick_idx;
                        grant    <= pick_onehot;
                        busy_reg <= 1'b1;
                        counter  <= '0;
                    end
                end
                S_grant: begin
                    if (accept) begin
                        counter <= counter + 8'd1;
                    end
                    // Always pass through S_idle so every grant has a gap cycle.
                    if (leave) begin
                        state    <= S_idle;
                        grant    <= '0;
                        busy_reg <= 1'b0;
                        rr_ptr   <= next_ptr;
                    end
                end
                default: begin
                    state    <= S_idle;
                    grant    <= '0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = grant;
    assign bus.busy       = busy_reg;
    assign bus.vga_x      = pix_x;
    assign bus.vga_y      = pix_y;
    assign bus.vga_colour = pix_colour;
    assign bus.vga_plot   = plot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed self-checking bench for vga_plot_arbiter.
// Two instances: BURST_MAX=4 for the single/burst/release/reset/bounds steps,
// BURST_MAX=1 for the rotation step. Expectations follow PLOT_BOUNDS_CHECK_EN.
module tb_vga_plot_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    vga_plot_arbiter_if #(.N_REQ(3)) bus4 ();
    vga_plot_arbiter_if #(.N_REQ(3)) bus1 ();

    vga_plot_arbiter #(
        .N_REQ     (3),
        .BURST_MAX (4)
    ) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    vga_plot_arbiter #(
        .N_REQ     (3),
        .BURST_MAX (1)
    ) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // Rotation with BURST_MAX=1: grant, gap (with plot), next grant, ...
    logic [2:0] rot_gnt  [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    logic       rot_plot [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] rot_x    [7] = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus4.req = '0; bus4.x_in = '0; bus4.y_in = '0; bus4.colour_in = '0;
        bus1.req = '0; bus1.x_in = '0; bus1.y_in = '0; bus1.colour_in = '0;

        // Reset state
        tick();
        tick();
        check("rst_gnt", bus4.gnt, 0);
        check("rst_busy", bus4.busy, 0);
        check("rst_plot", bus4.vga_plot, 0);
        check("rst_xyc", {bus4.vga_x, bus4.vga_y, bus4.vga_colour}, 0);
        check("rst_oob", bus4.oob_flag, 0);
        check("rst_gnt1", bus1.gnt, 0);
        reset = 1'b0;

        // Single requester, held through a whole burst and a re-win
        bus4.x_in[7:0] = 8'd10; bus4.y_in[6:0] = 7'd20; bus4.colour_in[2:0] = 3'd7;
        bus4.req = 3'b001;
        check("single_idle_gnt", bus4.gnt, 0);
        tick();
        check("single_gnt", bus4.gnt, 3'b001);
        check("single_busy", bus4.busy, 1);
        check("single_plot_lat", bus4.vga_plot, 0);
        tick();
        check("single_plot", bus4.vga_plot, 1);
        check("single_x", bus4.vga_x, 10);
        check("single_y", bus4.vga_y, 20);
        check("single_c", bus4.vga_colour, 7);
        tick();
        tick();
        check("single_beat3", bus4.vga_plot, 1);
        tick();
        check("single_beat4", bus4.vga_plot, 1);
        check("single_gap_gnt", bus4.gnt, 0);
        check("single_gap_busy", bus4.busy, 0);
        tick();
        check("single_rewin_gnt", bus4.gnt, 3'b001);
        check("single_rewin_plot", bus4.vga_plot, 0);
        bus4.req = 3'b000;
        tick();
        check("single_drop_gnt", bus4.gnt, 0);
        check("single_drop_plot", bus4.vga_plot, 0);
        check("single_hold_x", bus4.vga_x, 10);

        // Burst limit with requesters 0 and 1
        pulse_reset();
        bus4.x_in[7:0] = 8'd11;
        bus4.x_in[15:8] = 8'd21; bus4.y_in[13:7] = 7'd22; bus4.colour_in[5:3] = 3'd3;
        bus4.x_in[23:16] = 8'd33; bus4.y_in[20:14] = 7'd44; bus4.colour_in[8:6] = 3'd5;
        bus4.req = 3'b011;
        tick();
        check("burst_gnt0", bus4.gnt, 3'b001);
        for (int b = 0; b < 4; b++) begin
            tick();
            check("burst_plot", bus4.vga_plot, 1);
            check("burst_x", bus4.vga_x, 11);
            check("burst_gnt", bus4.gnt, (b < 3) ? 3'b001 : 3'b000);
        end
        tick();
        check("burst_gnt1", bus4.gnt, 3'b010);
        check("burst_gap_plot", bus4.vga_plot, 0);

        // Early release by owner 1 with requester 2 waiting
        bus4.req = 3'b110;
        tick();
        check("rel_plot1", bus4.vga_plot, 1);
        check("rel_xyc1", {bus4.vga_x, bus4.vga_y, bus4.vga_colour}, {8'd21, 7'd22, 3'd3});
        tick();
        check("rel_plot2", bus4.vga_plot, 1);
        bus4.req = 3'b100;
        tick();
        check("rel_idle_gnt", bus4.gnt, 0);
        check("rel_idle_plot", bus4.vga_plot, 0);
        check("rel_hold_x", bus4.vga_x, 21);
        tick();
        check("rel_gnt2", bus4.gnt, 3'b100);
        check("rel_gnt2_plot", bus4.vga_plot, 0);

        // Mid-burst reset on beat 3 of requester 2
        tick();
        check("mrst_beat1", bus4.vga_x, 33);
        tick();
        check("mrst_beat2", bus4.vga_plot, 1);
        #3;
        reset = 1'b1;
        #1;
        check("mrst_gnt_now", bus4.gnt, 0);
        check("mrst_busy_now", bus4.busy, 0);
        check("mrst_plot_now", bus4.vga_plot, 0);
        tick();
        check("mrst_beat3_plot", bus4.vga_plot, 0);
        check("mrst_x_clear", bus4.vga_x, 0);
        reset = 1'b0;
        // rr_ptr was 2 before reset; requester 0 must win if it returned to 0.
        bus4.req = 3'b101;
        check("mrst_idle_gnt", bus4.gnt, 0);
        tick();
        check("mrst_ptr_gnt", bus4.gnt, 3'b001);
        bus4.req = 3'b000;
        tick();
        tick();

        // Off-screen beat (160,5)
        bus4.x_in[7:0] = 8'd160; bus4.y_in[6:0] = 7'd5; bus4.colour_in[2:0] = 3'd6;
        bus4.req = 3'b001;
        tick();
        check("oob_gnt", bus4.gnt, 3'b001);
        tick();
`ifdef PLOT_BOUNDS_CHECK_EN
        check("oob_plot", bus4.vga_plot, 0);
        check("oob_flag", bus4.oob_flag, 1);
`else
        check("oob_plot", bus4.vga_plot, 1);
        check("oob_xy", {bus4.vga_x, bus4.vga_y}, {8'd160, 7'd5});
        check("oob_flag", bus4.oob_flag, 0);
`endif
        bus4.req = 3'b000;
        tick();
        tick();
`ifdef PLOT_BOUNDS_CHECK_EN
        check("oob_sticky", bus4.oob_flag, 1);
`else
        check("oob_tied", bus4.oob_flag, 0);
`endif

        // Rotation with BURST_MAX=1, all three requesting
        pulse_reset();
        bus1.x_in = {8'd3, 8'd2, 8'd1};
        bus1.req = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("rot_gnt", bus1.gnt, rot_gnt[k]);
            check("rot_plot", bus1.vga_plot, rot_plot[k]);
            if (rot_plot[k]) begin
                check("rot_x", bus1.vga_x, rot_x[k]);
            end
        end
        bus1.req = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_REQ, 3, number of requesters (0 = screen clear, 1 = circle, 2 = spare).
  BURST_MAX, 64, maximum accepted beats per grant.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  req  in  N_REQ  per-requester request; also the beat-valid while granted.
  x_in  in  N_REQ*8  packed pixel x per requester.
  y_in  in  N_REQ*7  packed pixel y per requester.
  colour_in  in  N_REQ*3  packed pixel colour per requester.
  gnt  out  N_REQ  one-hot grant, registered.
  busy  out  1  high while a grant is held.
  vga_x  out  8  to the VGA adapter.
  vga_y  out  7  to the VGA adapter.
  vga_colour  out  3  to the VGA adapter.
  vga_plot  out  1  adapter write enable.
  oob_flag  out  1  sticky out-of-bounds indicator.
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be S_idle and S_grant.
REQ-005 In S_idle with any req high, the winner SHALL be the first requester at or after rr_ptr (mod N_REQ), stored in owner. The FSM SHALL enter S_grant on the next edge.
REQ-006 gnt[owner] and busy SHALL be 1 exactly while in S_grant. All gnt bits SHALL be 0 in S_idle.
REQ-007 A beat SHALL be accepted when req[owner] & gnt[owner]. Its x, y and colour SHALL be registered into vga_x, vga_y and vga_colour, with vga_plot=1 one cycle later (latency 1).
REQ-008 Without an accepted beat, vga_plot SHALL be 0 and vga_x, vga_y and vga_colour SHALL hold their values.
REQ-009 An 8-bit beat counter SHALL clear on entry to S_grant and increment per accepted beat.
REQ-010 The FSM SHALL leave S_grant for S_idle when req[owner]=0, or when a beat is accepted with counter = BURST_MAX-1 (that beat is written).
REQ-011 On leaving S_grant, rr_ptr SHALL become (owner+1) mod N_REQ.
REQ-012 S_idle SHALL last at least one cycle between grants (turnaround gap), even when the same requester re-wins.
REQ-013 A requester whose grant expired while it still requests SHALL keep req high. It SHALL be re-arbitrated without losing its pending pixel, because unaccepted beats are not consumed.
REQ-014 Requests from non-owners during S_grant SHALL be ignored until S_idle.
REQ-015 BURST_MAX=1 SHALL give one beat per grant.

Reset
REQ-016 On reset: state=S_idle, rr_ptr=0, owner=0, counter=0, gnt=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, oob_flag=0.
REQ-017 Reset mid-burst SHALL drop the grant immediately. A beat accepted in the cycle of reset assertion SHALL NOT be plotted.

Configuration
REQ-018 Macro PLOT_BOUNDS_CHECK_EN, when defined, SHALL apply to any accepted beat with x>=160 or y>=120:
  beat still consumed and counted;
  vga_plot held 0;
  oob_flag set until reset.
REQ-019 When PLOT_BOUNDS_CHECK_EN is undefined, all accepted beats SHALL be plotted unchanged, and oob_flag SHALL be tied 0.

Structure
REQ-020 Package vga_pkg SHALL hold:
  X_W=8, Y_W=7, COLOUR_W=3;
  SCREEN_W=160, SCREEN_H=120;
  the arbiter state enum typedef.
REQ-021 Sub-module rr_picker SHALL implement the combinational round-robin select (req, rr_ptr -> one-hot winner and index). All else SHALL be in vga_plot_arbiter.

Verification
REQ-022 Single requester scenario:
  stimulus: reset, then req=001 held with x_in[0]=10, y_in[0]=20, colour_in[0]=7;
  response: gnt=001 one cycle later; vga_plot=1 with (10,20,7) the following cycle.
REQ-023 Burst limit scenario:
  stimulus: BURST_MAX=4, req=011 held;
  response: gnt=001 for exactly 4 beats, then 1 cycle all-zero gnt, then gnt=010.
REQ-024 Early release scenario:
  stimulus: owner 1 drops req after 2 beats while req[2]=1;
  response: exactly 2 plots; S_idle one cycle; gnt=100.
REQ-025 Mid-burst reset scenario:
  stimulus: reset asserted on beat 3 of a burst;
  response: gnt=0 and vga_plot=0 immediately; rr_ptr=0 after release.
REQ-026 Bounds check scenario (PLOT_BOUNDS_CHECK_EN defined):
  stimulus: beat (160,5);
  response: vga_plot stays 0 and oob_flag=1.
  Without the macro: same beat plots (160,5); oob_flag=0.
REQ-027 Fairness scenario:
  stimulus: all three req held continuously with BURST_MAX=1;
  response: grants rotate 001, 010, 100, 001.
